// File: rtl/mux32_arbiter_pkg.sv
// Shared definitions for the two-requester 32-bit arbiter: FSM state
// encoding, source identifiers and datapath widths.
package mux32_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int STREAK_W = 4;   // wide enough for HOLD_MAX up to 15

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux32_arbiter_mux.sv
// Mux32: 32-bit two-way word selector. sel=0 passes a, sel=1 passes b.
module mux32
  import mux32_arbiter_pkg::*;
(
  input  logic              sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux32_arbiter.sv
// Two-requester round-robin arbiter feeding a one-word output register.
// A word is granted only when the output register is empty or being
// drained this cycle, giving one word per cycle when the consumer is ready.
// Optional build macro MUX32_ARBITER_LOCK_EN adds a_lock/b_lock, which let
// the last-granted requester keep priority for up to HOLD_MAX grants.
module mux32_arbiter
  import mux32_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [DATA_W-1:0] b_data,
  input  logic              out_ready,
`ifdef MUX32_ARBITER_LOCK_EN
  input  logic              a_lock,
  input  logic              b_lock,
`endif
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
);

  state_t            state, state_nxt;
  logic              last_src;
  logic              load_ok;
  logic              grant;
  logic              winner;
  logic [DATA_W-1:0] mux_y;

`ifdef MUX32_ARBITER_LOCK_EN
  localparam logic [STREAK_W-1:0] HOLD_LIM = STREAK_W'(HOLD_MAX);

  // Number of consecutive locked grants to last_src, saturating.
  logic [STREAK_W-1:0] streak;
  logic                last_lock;
  logic                win_lock;

  assign last_lock = (last_src == SRC_A) ? a_lock : b_lock;
  assign win_lock  = (winner   == SRC_A) ? a_lock : b_lock;
`endif

  assign load_ok = (state == ST_EMPTY) || out_ready;

  // Arbitration: sole requester wins; ties alternate away from last_src.
  always_comb begin
    // NOTE: default first so every path assigns winner; no latch inferred.
    winner = SRC_A;
    if (a_req && !b_req) begin
      winner = SRC_A;
    end else if (!a_req && b_req) begin
      winner = SRC_B;
    end else if (a_req && b_req) begin
      winner = ~last_src;
`ifdef MUX32_ARBITER_LOCK_EN
      if (last_lock && (streak < HOLD_LIM)) winner = last_src;
`endif
    end
  end

  mux32 u_mux32 (
    .sel (winner),
    .a   (a_data),
    .b   (b_data),
    .y   (mux_y)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all clocked state to avoid races.
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // FSM next state: fill on grant, drain when taken with no replacement.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant)               state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !grant) state_nxt = ST_EMPTY;
      default:                           state_nxt = ST_EMPTY;
    endcase
  end

  // FSM outputs: grants are combinational and gated by load_ok.
  always_comb begin
    grant     = load_ok && (a_req || b_req);
    a_gnt     = grant && (winner == SRC_A);
    b_gnt     = grant && (winner == SRC_B);
    out_valid = (state == ST_FULL);
  end

  // Output word register and round-robin history, loaded on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset because out_data must read 0 in reset.
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= SRC_A;
      last_src <= SRC_B;
    end else if (grant) begin
      out_data <= mux_y;
      out_src  <= winner;
      last_src <= winner;
    end
  end

`ifdef MUX32_ARBITER_LOCK_EN
  // Streak counter: counts locked back-to-back grants, restarts on change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant) begin
      if (!win_lock)               streak <= '0;
      else if (winner != last_src) streak <= STREAK_W'(1);
      else if (streak != '1)       streak <= streak + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux32_arbiter.sv
// Self-checking bench for mux32_arbiter: directed table, hand sequences
// for stall / async reset / lock, and randomized traffic vs. a model.
module tb_mux32_arbiter;

  localparam int HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0, out_ready = 1'b0;
  logic [31:0] a_data = '0, b_data = '0;
`ifdef MUX32_ARBITER_LOCK_EN
  logic        a_lock = 1'b0, b_lock = 1'b0;
`endif
  logic        a_gnt, b_gnt, out_valid, out_src;
  logic [31:0] out_data;

  mux32_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_data    (a_data),
    .b_req     (b_req),
    .b_data    (b_data),
    .out_ready (out_ready),
`ifdef MUX32_ARBITER_LOCK_EN
    .a_lock    (a_lock),
    .b_lock    (b_lock),
`endif
    .a_gnt     (a_gnt),
    .b_gnt     (b_gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one output slot, fairness history, lock run length.
  bit          m_valid;
  logic [31:0] m_data;
  bit          m_src;
  bit          m_last;
  int          m_run;

  function automatic void m_reset();
    m_valid = 0; m_data = '0; m_src = 0; m_last = 1; m_run = 0;
  endfunction

  // Who should get the word this cycle given current inputs.
  task automatic m_predict(output bit ga, output bit gb, output bit w);
    bool_room: begin end
    w = 0;
    if (a_req && !b_req) w = 0;
    else if (b_req && !a_req) w = 1;
    else if (a_req && b_req) begin
      w = !m_last;
`ifdef MUX32_ARBITER_LOCK_EN
      if ((m_last ? b_lock : a_lock) && m_run < HOLD_MAX) w = m_last;
`endif
    end
    ga = (!m_valid || out_ready) && (a_req || b_req) && !w;
    gb = (!m_valid || out_ready) && (a_req || b_req) && w;
  endtask

  task automatic m_update(input bit ga, input bit gb, input bit w);
    if (ga || gb) begin
`ifdef MUX32_ARBITER_LOCK_EN
      if (!(w ? b_lock : a_lock)) m_run = 0;
      else if (w != m_last)       m_run = 1;
      else if (m_run < 15)        m_run = m_run + 1;
`endif
      m_valid = 1;
      m_data  = w ? b_data : a_data;
      m_src   = w;
      m_last  = w;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  // One model-checked cycle; entered and left at a falling edge.
  task automatic run_cycle(input string tag);
    bit ga, gb, w;
    #2;
    m_predict(ga, gb, w);
    check({tag, "_a_gnt"}, a_gnt, ga);
    check({tag, "_b_gnt"}, b_gnt, gb);
    @(posedge clk);
    m_update(ga, gb, w);
    #1;
    check({tag, "_valid"}, out_valid, m_valid);
    if (m_valid) begin
      check({tag, "_data"}, out_data, m_data);
      check({tag, "_src"}, out_src, m_src);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; a_req = 0; b_req = 0; out_ready = 0;
`ifdef MUX32_ARBITER_LOCK_EN
    a_lock = 0; b_lock = 0;
`endif
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 32'h0);
    check("rst_src", out_src, 0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  typedef struct {
    bit          a_req, b_req, rdy;
    logic [31:0] ad, bd;
    bit          ea, eb, ev;
    logic [31:0] ed;
    bit          es;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked with no clock edge having occurred.
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 32'h0);
    check("rst_src", out_src, 0);
    check("rst_a_gnt", a_gnt, 0);

    // a_req, b_req, ready, a_data, b_data -> a_gnt, b_gnt, then valid/data/src
    tbl[0]  = '{1, 0, 1, 32'h55555555, 32'hAAAAAAAA, 1, 0, 1, 32'h55555555, 0};
    tbl[1]  = '{1, 1, 1, 32'h55555555, 32'hAAAAAAAA, 0, 1, 1, 32'hAAAAAAAA, 1};
    tbl[2]  = '{1, 1, 1, 32'h55555555, 32'hAAAAAAAA, 1, 0, 1, 32'h55555555, 0};
    tbl[3]  = '{1, 1, 1, 32'h55555555, 32'hAAAAAAAA, 0, 1, 1, 32'hAAAAAAAA, 1};
    tbl[4]  = '{1, 1, 0, 32'h55555555, 32'hAAAAAAAA, 0, 0, 1, 32'hAAAAAAAA, 1};
    tbl[5]  = '{0, 0, 1, 32'h55555555, 32'hAAAAAAAA, 0, 0, 0, 32'hAAAAAAAA, 1};
    tbl[6]  = '{0, 1, 1, 32'hEFFFFFFF, 32'h00000000, 0, 1, 1, 32'h00000000, 1};
    tbl[7]  = '{1, 0, 0, 32'hEFFFFFFF, 32'h00000000, 0, 0, 1, 32'h00000000, 1};
    tbl[8]  = '{1, 0, 1, 32'h12345678, 32'h00000000, 1, 0, 1, 32'h12345678, 0};
    tbl[9]  = '{0, 0, 0, 32'h12345678, 32'h00000000, 0, 0, 1, 32'h12345678, 0};
    tbl[10] = '{0, 0, 1, 32'h12345678, 32'h00000000, 0, 0, 0, 32'h12345678, 0};

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 11; i++) begin
      a_req = tbl[i].a_req; b_req = tbl[i].b_req; out_ready = tbl[i].rdy;
      a_data = tbl[i].ad; b_data = tbl[i].bd;
      #2;
      check($sformatf("tbl%0d_a_gnt", i), a_gnt, tbl[i].ea);
      check($sformatf("tbl%0d_b_gnt", i), b_gnt, tbl[i].eb);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      check($sformatf("tbl%0d_src", i), out_src, tbl[i].es);
      @(negedge clk);
    end

    // Consumer stall: FULL, both requesting, ready low for 5 cycles.
    do_reset();
    a_req = 1; b_req = 1; a_data = 32'h55555555; b_data = 32'hAAAAAAAA;
    out_ready = 1;
    run_cycle("stall_fill");
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_no_gnt", {31'b0, a_gnt | b_gnt}, 32'h0);
      run_cycle("stall");
      check("stall_data_held", out_data, 32'h55555555);
    end
    out_ready = 1;
    #1;
    check("resume_b_gnt", b_gnt, 1);
    run_cycle("resume");

    // Asynchronous reset while a word is held.
    run_cycle("pre_rst");
    #3;
    rst_n = 0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1;
    m_reset();
    #1;
    check("post_rst_tie_a", a_gnt, 1);
    run_cycle("post_rst");

    // Lock: with the macro A keeps 4 grants then yields; else alternation.
    do_reset();
    a_req = 1; b_req = 1; out_ready = 1;
`ifdef MUX32_ARBITER_LOCK_EN
    a_lock = 1;
`endif
    for (int i = 0; i < 10; i++) begin
      bit exp_b;
`ifdef MUX32_ARBITER_LOCK_EN
      exp_b = (i % 5) == 4;
`else
      exp_b = (i % 2) == 1;
`endif
      #1;
      check($sformatf("lock_seq%0d_b", i), b_gnt, exp_b);
      run_cycle("lock");
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a_req = 1'($urandom_range(0, 1));
      b_req = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a_data = $urandom;
      b_data = $urandom;
`ifdef MUX32_ARBITER_LOCK_EN
      a_lock = ($urandom_range(0, 3) != 0);
      b_lock = ($urandom_range(0, 3) == 0);
`endif
      run_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
